// File: rtl/sram_ctrl_if.sv
// CPU-side request/response bundle of the SRAM sequencer (one transfer at a time).
interface sram_ctrl_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [1:0]        be;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              done;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, be, addr, wdata, input ready, done, rdata);
  modport slave  (input req, we, be, addr, wdata, output ready, done, rdata);
endinterface

// File: rtl/sram_ctrl.sv
// Async SRAM sequencer: IDLE -> SETUP -> ACCESS x WAIT_CYCLES -> HOLD(done); accept-to-done is WAIT_CYCLES+2.
// No queueing: req is only sampled while ready (IDLE); all strobes and outputs are registered.
module sram_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  sram_ctrl_if.slave        bus,
  output logic [ADDR_W-1:0] A,
  inout  wire  [DATA_W-1:0] Mem_bus,
  output logic              CE_out,
  output logic              OE_out,
  output logic              WE_out,
  output logic              UB_out,
  output logic              LB_out
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              op_we_q, op_we_d;
  logic [1:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              ce_q, ce_d;
  logic              oe_q, oe_d;
  logic              we_n_q, we_n_d;
  logic              ub_q, ub_d;
  logic              lb_q, lb_d;
  logic              drv_q, drv_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_we_d = op_we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          state_d = SETUP;
          op_we_d = bus.we;
          be_d    = bus.be;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = 4'(WAIT_CYCLES);
      end
      ACCESS: begin
        if (cnt_q <= 4'd1) begin
          state_d = HOLD;
          cnt_d   = 4'd0;
          if (!op_we_q) rdata_d = Mem_bus;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are decoded from the next state so they change together with it.
    ready_d = (state_d == IDLE);
    done_d  = (state_d == HOLD);
    ce_d    = (state_d == IDLE);
    oe_d    = !(!op_we_d && (state_d == SETUP || state_d == ACCESS));
    we_n_d  = !(op_we_d && state_d == ACCESS);
    ub_d    = (state_d == IDLE) || !be_d[1];
    lb_d    = (state_d == IDLE) || !be_d[0];
    drv_d   = op_we_d && (state_d == ACCESS || state_d == HOLD);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_we_q <= 1'b0;
      be_q    <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      ce_q    <= 1'b1;
      oe_q    <= 1'b1;
      we_n_q  <= 1'b1;
      ub_q    <= 1'b1;
      lb_q    <= 1'b1;
      drv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_we_q <= op_we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      ce_q    <= ce_d;
      oe_q    <= oe_d;
      we_n_q  <= we_n_d;
      ub_q    <= ub_d;
      lb_q    <= lb_d;
      drv_q   <= drv_d;
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
  assign A         = addr_q;
  assign CE_out    = ce_q;
  assign OE_out    = oe_q;
  assign WE_out    = we_n_q;
  assign UB_out    = ub_q;
  assign LB_out    = lb_q;
  assign Mem_bus   = drv_q ? wdata_q : {DATA_W{1'bz}};
endmodule
